// File: rtl/uart_prog_loader.sv
// UART 8N1 program/data loader: A5|TGT|LEN_LO|LEN_HI|data[|CKSUM] frames -> one-hot target word writes.
// Write strobe 1 cycle after the last byte of a word; no backpressure (the serial line cannot be stalled).
// Optional trailing checksum byte built only with `define UART_PROG_LOADER_CKSUM_EN.
module uart_prog_loader #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int N_TGT       = 2,
  parameter int TIMEOUT_BIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              uart_rxd,
  output logic              wr_en,
  output logic [N_TGT-1:0]  wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DIV    = CLK_FREQ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int BPW    = DATA_W / 8;
  localparam int TO_CYC = TIMEOUT_BIT * DIV;
  localparam int CNT_W  = $clog2(DIV + 1);
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int BI_W   = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_TGT, S_LEN0, S_LEN1, S_DATA,
`ifdef UART_PROG_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_FIN
  } state_t;

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_s1, rx_s2, rx_s3;
  logic             byte_vld, frame_err;

  state_t            state, state_n;
  logic [N_TGT-1:0]  sel, sel_n;
  logic [7:0]        len_lo, len_lo_n;
  logic [15:0]       words, words_n;
  logic [BI_W-1:0]   bidx, bidx_n;
  logic [DATA_W-1:0] wbuf, wbuf_n, word_ins;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic              wr_en_n, done_n, err_n;
  logic [N_TGT-1:0]  wr_sel_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;
`ifdef UART_PROG_LOADER_CKSUM_EN
  logic [7:0]        ck, ck_n;
`endif

  // Receiver: rx_s3 holds the previous synchronised sample for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CNT_W'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    if (!enable) begin
      rx_state_n = RX_IDLE;
      rx_cnt_n   = '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt_n = '0;
          if (rx_s3 && !rx_s2) rx_state_n = RX_START;
        end
        RX_START: begin
          if (rx_cnt == CNT_W'(HALF - 1)) begin
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_W'(DIV - 1)) begin
            rx_cnt_n   = '0;
            rx_shift_n = {rx_s2, rx_shift[7:1]};
            rx_bit_n   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_W'(DIV - 1)) begin
            rx_cnt_n   = '0;
            rx_state_n = RX_IDLE;
            if (rx_s2) byte_vld  = 1'b1;
            else       frame_err = 1'b1;
          end
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sel     <= '0;
      len_lo  <= '0;
      words   <= '0;
      bidx    <= '0;
      wbuf    <= '0;
      addr    <= '0;
      to_cnt  <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef UART_PROG_LOADER_CKSUM_EN
      ck      <= '0;
`endif
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      len_lo  <= len_lo_n;
      words   <= words_n;
      bidx    <= bidx_n;
      wbuf    <= wbuf_n;
      addr    <= addr_n;
      to_cnt  <= to_n;
      wr_en   <= wr_en_n;
      wr_sel  <= wr_sel_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      done    <= done_n;
      err     <= err_n;
`ifdef UART_PROG_LOADER_CKSUM_EN
      ck      <= ck_n;
`endif
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    word_ins = wbuf;
    word_ins[int'(bidx)*8 +: 8] = rx_shift;
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    len_lo_n  = len_lo;
    words_n   = words;
    bidx_n    = bidx;
    wbuf_n    = wbuf;
    addr_n    = addr;
    to_n      = byte_vld ? '0 : to_cnt + TO_W'(1);
    wr_en_n   = 1'b0;
    wr_sel_n  = '0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
`ifdef UART_PROG_LOADER_CKSUM_EN
    ck_n      = byte_vld ? ck + rx_shift : ck;
`endif
    if (!enable) begin
      state_n = S_IDLE;
      to_n    = '0;
    end else if (state != S_IDLE && frame_err) begin
      err_n   = 1'b1;
      state_n = S_IDLE;
    end else if (state != S_IDLE && state != S_FIN && to_cnt == TO_W'(TO_CYC - 1)) begin
      err_n   = 1'b1;
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          to_n = '0;
          if (byte_vld && rx_shift == 8'hA5) begin
            state_n = S_TGT;
`ifdef UART_PROG_LOADER_CKSUM_EN
            ck_n    = '0;
`endif
          end
        end
        S_TGT: begin
          if (byte_vld) begin
            if (int'(rx_shift) < N_TGT) begin
              for (int i = 0; i < N_TGT; i++) sel_n[i] = (rx_shift == 8'(i));
              state_n = S_LEN0;
            end else begin
              err_n   = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
        S_LEN0: begin
          if (byte_vld) begin
            len_lo_n = rx_shift;
            state_n  = S_LEN1;
          end
        end
        S_LEN1: begin
          if (byte_vld) begin
            words_n = {rx_shift, len_lo};
            bidx_n  = '0;
            addr_n  = '0;
            if ({rx_shift, len_lo} == 16'd0) begin
`ifdef UART_PROG_LOADER_CKSUM_EN
              state_n = S_CKSUM;
`else
              done_n  = 1'b1;
              state_n = S_IDLE;
`endif
            end else begin
              state_n = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (byte_vld) begin
            wbuf_n = word_ins;
            if (bidx == BI_W'(BPW - 1)) begin
              bidx_n    = '0;
              wr_en_n   = 1'b1;
              wr_sel_n  = sel;
              wr_addr_n = addr;
              wr_data_n = word_ins;
              addr_n    = addr + ADDR_W'(BPW);
              words_n   = words - 16'd1;
              if (words == 16'd1) begin
`ifdef UART_PROG_LOADER_CKSUM_EN
                state_n = S_CKSUM;
`else
                state_n = S_FIN;
`endif
              end
            end else begin
              bidx_n = bidx + BI_W'(1);
            end
          end
        end
`ifdef UART_PROG_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (byte_vld) begin
            if (rx_shift == ck) done_n = 1'b1;
            else                err_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
`endif
        // One-cycle gap so done lands the cycle after the final write.
        S_FIN: begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at DIV=16 (1.6 MHz / 100 kBd), 32-bit words, 2 targets.
module tb_uart_prog_loader;

  localparam int DIV = 16;

  logic        clk, rst, enable, uart_rxd;
  logic        wr_en, busy, done, err;
  logic [1:0]  wr_sel;
  logic [31:0] wr_addr, wr_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int err_cyc = 0;
  int n_done = 0, n_errp = 0, n_both = 0, n_busy_bad = 0;
  logic [31:0] wa[$], wd[$];
  logic [1:0]  ws[$];
  logic [7:0]  tx_q[$];
  int b_w, b_d, b_e;

  uart_prog_loader #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_W(32), .ADDR_W(32),
    .N_TGT(2), .TIMEOUT_BIT(64)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .uart_rxd(uart_rxd),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      ws.push_back(wr_sel);
    end
    if (done) n_done++;
    if (err) begin
      n_errp++;
      err_cyc = cyc;
    end
    if (done && err) n_both++;
    if ((done || err) && busy) n_busy_bad++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    uart_rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(DIV);
    end
    stop_cyc = cyc;
    uart_rxd = stop_val;
    tick(DIV);
    uart_rxd = 1'b1;
    tick(2);
  endtask

  task automatic send_q();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
  endtask

  // Appends the 8-bit sum of everything after the 0xA5 sync byte when the checksum build is used.
  task automatic send_frame();
`ifdef UART_PROG_LOADER_CKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    for (int i = 1; i < tx_q.size(); i++) s = s + tx_q[i];
    tx_q.push_back(s);
`endif
    send_q();
  endtask

  task automatic snap();
    b_w = wa.size();
    b_d = n_done;
    b_e = n_errp;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wr_en"},   wr_en, 1'b0);
    check({tag, " wr_sel"},  wr_sel, 2'b00);
    check({tag, " wr_addr"}, wr_addr, 32'h0);
    check({tag, " wr_data"}, wr_data, 32'h0);
    check({tag, " busy"},    busy, 1'b0);
    check({tag, " done"},    done, 1'b0);
    check({tag, " err"},     err, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    uart_rxd = 1'b1;
    tick(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(5);

    // Two-word frame to target 0.
    snap();
    tx_q = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame();
    tick(4 * DIV);
    check("t1 nwrites", wa.size() - b_w, 2);
    if (wa.size() - b_w == 2) begin
      check("t1 addr0", wa[b_w], 32'h0);
      check("t1 data0", wd[b_w], 32'h0000_0013);
      check("t1 sel0",  ws[b_w], 2'b01);
      check("t1 addr1", wa[b_w+1], 32'h4);
      check("t1 data1", wd[b_w+1], 32'h0010_0093);
    end
    check("t1 done", n_done - b_d, 1);
    check("t1 err",  n_errp - b_e, 0);

    // One word to target 1, little-endian assembly.
    snap();
    tx_q = {8'hA5, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    tick(4 * DIV);
    check("t2 nwrites", wa.size() - b_w, 1);
    if (wa.size() - b_w == 1) begin
      check("t2 addr", wa[b_w], 32'h0);
      check("t2 data", wd[b_w], 32'hDEAD_BEEF);
      check("t2 sel",  ws[b_w], 2'b10);
    end
    check("t2 done", n_done - b_d, 1);

    // Target out of range.
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    tick(2 * DIV);
    check("t3 err", n_errp - b_e, 1);
    check("t3 err timing", (err_cyc > stop_cyc) && (err_cyc < stop_cyc + DIV), 1'b1);
    check("t3 nwrites", wa.size() - b_w, 0);
    check("t3 busy", busy, 1'b0);
    snap();
    tx_q = {8'hA5, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    tick(4 * DIV);
    check("t3 recover done", n_done - b_d, 1);
    check("t3 recover nwrites", wa.size() - b_w, 1);
    if (wa.size() - b_w == 1) check("t3 recover data", wd[b_w], 32'hDEAD_BEEF);

    // Framing error on the second data byte.
    snap();
    send_byte(8'hA5, 1'b1);
    check("t4 busy after sync", busy, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    tick(2 * DIV);
    check("t4 err", n_errp - b_e, 1);
    check("t4 err timing", (err_cyc > stop_cyc) && (err_cyc < stop_cyc + DIV), 1'b1);
    check("t4 nwrites", wa.size() - b_w, 0);
    check("t4 busy", busy, 1'b0);
    check("t4 done", n_done - b_d, 0);

    // Inter-byte timeout with a partial word pending.
    snap();
    tx_q = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send_q();
    tick(60 * DIV);
    check("t5 no early timeout", n_errp - b_e, 0);
    check("t5 busy before timeout", busy, 1'b1);
    tick(6 * DIV);
    check("t5 timeout err", n_errp - b_e, 1);
    check("t5 nwrites", wa.size() - b_w, 0);
    check("t5 busy", busy, 1'b0);

    // enable dropped mid-DATA after the first word.
    snap();
    tx_q = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_q();
    enable = 1'b0;
    tick(1);
    check("t5b busy", busy, 1'b0);
    tick(1);
    enable = 1'b1;
    tick(70 * DIV);
    check("t5b nwrites", wa.size() - b_w, 1);
    if (wa.size() - b_w == 1) check("t5b data", wd[b_w], 32'h4433_2211);
    check("t5b err", n_errp - b_e, 0);
    check("t5b done", n_done - b_d, 0);

`ifdef UART_PROG_LOADER_CKSUM_EN
    // Wrong checksum: the write stays, the frame fails.
    snap();
    tx_q = {8'hA5, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    send_q();
    tick(4 * DIV);
    check("t6 bad ck nwrites", wa.size() - b_w, 1);
    check("t6 bad ck err", n_errp - b_e, 1);
    check("t6 bad ck done", n_done - b_d, 0);
    snap();
    tx_q = {8'hA5, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h3A};
    send_q();
    tick(4 * DIV);
    check("t6 good ck done", n_done - b_d, 1);
    check("t6 good ck err", n_errp - b_e, 0);
`endif

    // Reset in the middle of a frame.
    snap();
    tx_q = {8'hA5, 8'h01, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_q();
    tick(5);
    check("t7 busy mid", busy, 1'b1);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("t7 rst");
    rst = 1'b0;
    tick(4 * DIV);
    check("t7 done", n_done - b_d, 0);
    check("t7 err", n_errp - b_e, 0);

    check("done&err together", n_both, 0);
    check("busy during pulse", n_busy_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
